psum_accumulator: RTL and testbench

- Sits directly downstream of the 4-kernel convolution top and consumes its four 32-bit signed partial sums, one pixel position per valid beat.
- Each input-channel pass produces one psum per lane per output pixel. The block accumulates these across NUM_CH passes in an on-chip ofmap buffer.
- On the last pass it adds the per-lane bias, applies ReLU, right-shifts with rounding, saturates, and emits 8-bit activations ready for the next layer's line buffer.

---
 rtl/conv_post_pkg.sv | 40 ++++
 rtl/psum_requant.sv | 31 +++
 rtl/psum_accumulator.sv | 165 ++++++++++++++++
 tb/tb_psum_accumulator.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/conv_post_pkg.sv
// rtl/conv_post_pkg.sv - shared types and arithmetic helpers for psum accumulation/requantization
package conv_post_pkg;

  localparam int LANES     = 4;
  localparam int DEF_ACC_W = 32;
  localparam int WIDE_W    = 64;

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  // Operands arrive sign-extended to WIDE_W; the result is clamped to signed w-bit bounds.
  function automatic logic signed [WIDE_W-1:0] sat_acc(input logic signed [WIDE_W-1:0] a,
                                                       input logic signed [WIDE_W-1:0] b,
                                                       input int w);
    logic signed [WIDE_W-1:0] sum;
    logic signed [WIDE_W-1:0] hi;
    logic signed [WIDE_W-1:0] lo;
    sum = a + b;
    hi  = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo  = -(64'sd1 <<< (w - 1));
    if (sum > hi) return hi;
    else if (sum < lo) return lo;
    else return sum;
  endfunction

  function automatic logic signed [WIDE_W-1:0] requant_wide(input logic signed [WIDE_W-1:0] v,
                                                            input logic [4:0] shift);
    logic signed [WIDE_W-1:0] r;
    r = (v < 0) ? '0 : v;
    if (shift != 5'd0) r = (r + (64'sd1 <<< (shift - 5'd1))) >>> shift;
    return r;
  endfunction

  function automatic logic [7:0] requant8(input logic signed [WIDE_W-1:0] v,
                                          input logic [4:0] shift);
    logic signed [WIDE_W-1:0] r;
    r = requant_wide(v, shift);
    return (r > 64'sd255) ? 8'd255 : r[7:0];
  endfunction

endpackage

// File: rtl/psum_requant.sv
// rtl/psum_requant.sv - one lane: saturating bias add, ReLU, rounded shift, clip to 8 bits
// Optional ACC_SAT_FLAG_EN exposes the bias-add saturation and 255-clip indicators.
module psum_requant
  import conv_post_pkg::*;
#(
  parameter int ACC_W = DEF_ACC_W
) (
  input  logic signed [WIDE_W-1:0] i_acc,
  input  logic signed [15:0]       i_bias,
  input  logic [4:0]               i_shift,
  output logic [7:0]               o_pix
`ifdef ACC_SAT_FLAG_EN
  ,
  output logic                     o_sat,
  output logic                     o_clip
`endif
);

  logic signed [WIDE_W-1:0] w_bias_x;
  logic signed [WIDE_W-1:0] w_final;

  assign w_bias_x = WIDE_W'(i_bias);
  assign w_final  = sat_acc(i_acc, w_bias_x, ACC_W);
  assign o_pix    = requant8(w_final, i_shift);

`ifdef ACC_SAT_FLAG_EN
  assign o_sat  = (w_final != (i_acc + w_bias_x));
  assign o_clip = (requant_wide(w_final, i_shift) > 64'sd255);
`endif

endmodule

// File: rtl/psum_accumulator.sv
// rtl/psum_accumulator.sv - accumulates 4-lane psums over NUM_CH passes and emits requantized 8-bit activations
// Optional ACC_SAT_FLAG_EN adds o_sat_flag, a sticky per-tile saturation/clip indicator.
module psum_accumulator
  import conv_post_pkg::*;
#(
  parameter int MAP_PIXELS = 1024,
  parameter int ACC_W      = DEF_ACC_W,
  parameter int CH_W       = 10
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_start,
  input  logic [CH_W-1:0]         i_num_ch,
  input  logic [4:0]              i_shift,
  input  logic                    i_psum_valid,
  input  logic signed [ACC_W-1:0] i_psum0,
  input  logic signed [ACC_W-1:0] i_psum1,
  input  logic signed [ACC_W-1:0] i_psum2,
  input  logic signed [ACC_W-1:0] i_psum3,
  input  logic signed [15:0]      i_bias0,
  input  logic signed [15:0]      i_bias1,
  input  logic signed [15:0]      i_bias2,
  input  logic signed [15:0]      i_bias3,
  output logic                    o_out_valid,
  output logic [7:0]              o_out_pix0,
  output logic [7:0]              o_out_pix1,
  output logic [7:0]              o_out_pix2,
  output logic [7:0]              o_out_pix3,
  output logic                    o_busy,
  output logic                    o_done
`ifdef ACC_SAT_FLAG_EN
  ,
  output logic                    o_sat_flag
`endif
);

  localparam int PIX_W = (MAP_PIXELS > 1) ? $clog2(MAP_PIXELS) : 1;
  localparam logic [PIX_W-1:0] LAST_PIX = PIX_W'(MAP_PIXELS - 1);

  state_t                  r_state, w_next_state;
  logic [PIX_W-1:0]        r_pix_cnt;
  logic [CH_W-1:0]         r_ch_cnt;
  logic [CH_W-1:0]         r_num_ch;
  logic [4:0]              r_shift;
  logic                    r_out_valid;
  logic [7:0]              r_out_pix [LANES];
  logic signed [ACC_W-1:0] r_buf [LANES][MAP_PIXELS];

  logic signed [ACC_W-1:0]  w_psum [LANES];
  logic signed [15:0]       w_bias [LANES];
  logic signed [WIDE_W-1:0] w_sum_x [LANES];
  logic [7:0]               w_pix [LANES];
  logic                     w_start, w_beat, w_last_ch, w_pix_wrap;

`ifdef ACC_SAT_FLAG_EN
  logic [LANES-1:0] w_acc_sat, w_fin_sat, w_clip;
  logic             r_sat_flag;
`endif

  assign w_psum     = '{i_psum0, i_psum1, i_psum2, i_psum3};
  assign w_bias     = '{i_bias0, i_bias1, i_bias2, i_bias3};
  assign w_start    = (r_state == IDLE) && i_start;
  assign w_beat     = (r_state == ACCUM) && i_psum_valid;
  assign w_last_ch  = (r_ch_cnt == (r_num_ch - CH_W'(1)));
  assign w_pix_wrap = (r_pix_cnt == LAST_PIX);

  // The first pass contributes a zero buffer term, so stale buffer contents never leak in.
  for (genvar g = 0; g < LANES; g++) begin : g_lane
    logic signed [WIDE_W-1:0] w_term_x, w_psum_x;
    assign w_term_x   = (r_ch_cnt == '0) ? '0 : WIDE_W'(r_buf[g][r_pix_cnt]);
    assign w_psum_x   = WIDE_W'(w_psum[g]);
    assign w_sum_x[g] = sat_acc(w_term_x, w_psum_x, ACC_W);

    psum_requant #(.ACC_W(ACC_W)) u_requant (
      .i_acc   (w_sum_x[g]),
      .i_bias  (w_bias[g]),
      .i_shift (r_shift),
      .o_pix   (w_pix[g])
`ifdef ACC_SAT_FLAG_EN
      ,
      .o_sat   (w_fin_sat[g]),
      .o_clip  (w_clip[g])
`endif
    );

`ifdef ACC_SAT_FLAG_EN
    assign w_acc_sat[g] = (w_sum_x[g] != (w_term_x + w_psum_x));
`endif
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst && w_beat && !w_last_ch) begin
      for (int l = 0; l < LANES; l++) r_buf[l][r_pix_cnt] <= w_sum_x[l][ACC_W-1:0];
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= IDLE;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    o_busy       = 1'b0;
    o_done       = 1'b0;
    unique case (r_state)
      IDLE:    if (i_start) w_next_state = ACCUM;
      ACCUM: begin
        o_busy = 1'b1;
        if (w_beat && w_last_ch && w_pix_wrap) w_next_state = DONE;
      end
      DONE: begin
        o_done       = 1'b1;
        w_next_state = IDLE;
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_pix_cnt   <= '0;
      r_ch_cnt    <= '0;
      r_num_ch    <= CH_W'(1);
      r_shift     <= '0;
      r_out_valid <= 1'b0;
      for (int l = 0; l < LANES; l++) r_out_pix[l] <= '0;
    end else begin
      r_out_valid <= 1'b0;
      if (w_start) begin
        r_num_ch  <= (i_num_ch == '0) ? CH_W'(1) : i_num_ch;
        r_shift   <= i_shift;
        r_pix_cnt <= '0;
        r_ch_cnt  <= '0;
      end else if (w_beat) begin
        if (w_pix_wrap) begin
          r_pix_cnt <= '0;
          r_ch_cnt  <= r_ch_cnt + CH_W'(1);
        end else begin
          r_pix_cnt <= r_pix_cnt + PIX_W'(1);
        end
        if (w_last_ch) begin
          r_out_valid <= 1'b1;
          for (int l = 0; l < LANES; l++) r_out_pix[l] <= w_pix[l];
        end
      end
    end
  end

`ifdef ACC_SAT_FLAG_EN
  always_ff @(posedge i_clk) begin
    if (i_rst || w_start) r_sat_flag <= 1'b0;
    else if (w_beat && ((|w_acc_sat) || (w_last_ch && ((|w_fin_sat) || (|w_clip)))))
      r_sat_flag <= 1'b1;
  end
  assign o_sat_flag = r_sat_flag;
`endif

  assign o_out_valid = r_out_valid;
  assign o_out_pix0  = r_out_pix[0];
  assign o_out_pix1  = r_out_pix[1];
  assign o_out_pix2  = r_out_pix[2];
  assign o_out_pix3  = r_out_pix[3];

endmodule

// File: tb/tb_psum_accumulator.sv
// tb/tb_psum_accumulator.sv - scoreboard bench for psum_accumulator with a behavioural reference model
module tb_psum_accumulator;

  localparam int MP   = 4;
  localparam int CH_W = 10;
  localparam longint AMAX = 64'sd2147483647;
  localparam longint AMIN = -64'sd2147483648;

  typedef struct packed {
    logic [31:0] pix;
    logic        last;
    int          cyc;
  } exp_t;

  logic clk = 1'b0, rst = 1'b1, start = 1'b0, psum_valid = 1'b0;
  logic [CH_W-1:0] num_ch = '0;
  logic [4:0] shift = '0;
  logic signed [31:0] ps [4];
  logic signed [15:0] bias [4];
  logic out_valid, busy, done;
  logic [7:0] op0, op1, op2, op3;
`ifdef ACC_SAT_FLAG_EN
  logic sat_flag;
`endif

  int passed = 0, total = 0, cyc = 0;
  exp_t sb [$];
  exp_t mon_e;
  logic [31:0] held = '0;
  longint m_acc [4][MP];

  psum_accumulator #(.MAP_PIXELS(MP), .ACC_W(32), .CH_W(CH_W)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_num_ch(num_ch), .i_shift(shift),
    .i_psum_valid(psum_valid),
    .i_psum0(ps[0]), .i_psum1(ps[1]), .i_psum2(ps[2]), .i_psum3(ps[3]),
    .i_bias0(bias[0]), .i_bias1(bias[1]), .i_bias2(bias[2]), .i_bias3(bias[3]),
    .o_out_valid(out_valid),
    .o_out_pix0(op0), .o_out_pix1(op1), .o_out_pix2(op2), .o_out_pix3(op3),
    .o_busy(busy), .o_done(done)
`ifdef ACC_SAT_FLAG_EN
    , .o_sat_flag(sat_flag)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint req);
    total++;
    if (act == req) passed++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
  endtask

  function automatic longint clampv(input longint v);
    return (v > AMAX) ? AMAX : ((v < AMIN) ? AMIN : v);
  endfunction

  function automatic longint rq(input longint f, input int sh);
    longint r;
    r = (f < 0) ? 0 : f;
    if (sh > 0) r = (r + (longint'(1) << (sh - 1))) / (longint'(1) << sh);
    return (r > 255) ? 255 : r;
  endfunction

  function automatic logic signed [31:0] gen(input int mode, input int pix, input int lane);
    int pat0 [4] = '{100, -50, 300, 7};
    int pat4 [4] = '{5, 4, -1, 600};
    if (mode == 1 && lane == 0) return pat0[pix];
    if (mode == 2 && lane == 1) return 10;
    if (mode == 3 && lane == 2) return 32'sh7FFFFFF0;
    if (mode == 4 && lane == 3) return pat4[pix];
    return int'($urandom_range(4000)) - 2000;
  endfunction

  // Output monitor: pops the scoreboard on every out_valid, otherwise checks hold behaviour.
  always @(negedge clk) begin
    if (rst) begin
      held <= '0;
    end else if (out_valid) begin
      if (sb.size() == 0) begin
        chk("unexpected_out_valid", 1, 0);
      end else begin
        mon_e = sb.pop_front();
        chk("out_pix", {op3, op2, op1, op0}, mon_e.pix);
        chk("latency_cycle", cyc, mon_e.cyc);
        chk("done_with_last", done, mon_e.last);
      end
      held <= {op3, op2, op1, op0};
    end else begin
      chk("pix_hold", {op3, op2, op1, op0}, held);
      chk("done_without_output", done, 0);
    end
  end

  task automatic set_bias_random();
    for (int l = 0; l < 4; l++) bias[l] = 16'(int'($urandom_range(1000)) - 500);
  endtask

  task automatic run_tile(input int nch, input int sh, input int gap, input int mode, input bit poke);
    int eff;
    longint p, t, f;
    exp_t e;
    eff = (nch == 0) ? 1 : nch;
    @(posedge clk); #1;
    start = 1'b1; num_ch = CH_W'(nch); shift = 5'(sh);
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_after_start", busy, 1);
`ifdef ACC_SAT_FLAG_EN
    chk("sat_flag_cleared", sat_flag, 0);
`endif
    for (int ch = 0; ch < eff; ch++) begin
      for (int pix = 0; pix < MP; pix++) begin
        e = '0;
        for (int l = 0; l < 4; l++) begin
          ps[l] = gen(mode, pix, l);
          p = longint'(ps[l]);
          if (ch < eff - 1) begin
            m_acc[l][pix] = (ch == 0) ? p : clampv(m_acc[l][pix] + p);
          end else begin
            t = (eff == 1) ? 0 : m_acc[l][pix];
            f = clampv(clampv(t + p) + longint'(bias[l]));
            e.pix[8*l +: 8] = 8'(rq(f, sh));
          end
        end
        if (ch == eff - 1) begin
          e.last = (pix == MP - 1);
          e.cyc  = cyc + 1;
          sb.push_back(e);
        end
        psum_valid = 1'b1;
        if (poke && ch == 0 && pix == 1) begin
          start = 1'b1; num_ch = CH_W'(5); shift = 5'd7;
        end
        @(posedge clk); #1;
        psum_valid = 1'b0;
        start = 1'b0;
        if (ch == eff - 1 && pix == MP - 1) begin
          chk("done_pulse", done, 1);
          chk("busy_low_at_done", busy, 0);
          @(posedge clk); #1;
          chk("done_one_cycle", done, 0);
          chk("scoreboard_drained", sb.size(), 0);
        end else begin
          repeat (gap) begin @(posedge clk); #1; end
        end
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got %0d/%0d", passed, total);
    $fatal(1);
  end

  initial begin
    for (int l = 0; l < 4; l++) begin ps[l] = '0; bias[l] = '0; end
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_out_pix", {op3, op2, op1, op0}, 0);
    rst = 1'b0;

    set_bias_random(); bias[0] = 16'sd5;
    run_tile(1, 0, 0, 1, 1'b0);
    set_bias_random(); bias[1] = -16'sd4;
    run_tile(3, 1, 0, 2, 1'b0);
    set_bias_random(); bias[3] = 16'sd0;
    run_tile(1, 1, 0, 4, 1'b0);
    run_tile(1, 2, 0, 4, 1'b0);
    set_bias_random(); bias[2] = 16'sd5;
    run_tile(2, 0, 0, 3, 1'b0);
`ifdef ACC_SAT_FLAG_EN
    chk("sat_flag_sticky", sat_flag, 1);
`endif

    // psum_valid while idle must not produce output nor disturb the next tile
    for (int i = 0; i < 3; i++) begin
      for (int l = 0; l < 4; l++) ps[l] = gen(0, 0, l);
      psum_valid = 1'b1;
      @(posedge clk); #1;
      chk("idle_busy", busy, 0);
    end
    psum_valid = 1'b0;
    set_bias_random();
    run_tile(2, 3, 0, 0, 1'b1);
    run_tile(0, 2, 0, 0, 1'b0);
    run_tile(3, 4, 3, 0, 1'b0);

    // reset during channel 1, pixel 2
    @(posedge clk); #1;
    start = 1'b1; num_ch = CH_W'(3); shift = 5'd0;
    @(posedge clk); #1;
    start = 1'b0;
    for (int b = 0; b < MP + 2; b++) begin
      for (int l = 0; l < 4; l++) ps[l] = gen(0, 0, l);
      psum_valid = 1'b1;
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; psum_valid = 1'b0;
    chk("midrst_busy", busy, 0);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_out_pix", {op3, op2, op1, op0}, 0);
    chk("midrst_done", done, 0);
    repeat (2) @(posedge clk);
    set_bias_random();
    run_tile(2, 2, 0, 0, 1'b0);

    for (int k = 0; k < 4; k++) begin
      set_bias_random();
      run_tile(int'($urandom_range(4, 1)), int'($urandom_range(6)), int'($urandom_range(2)), 0, 1'b0);
    end

    repeat (3) @(posedge clk);
    #1;
    chk("final_scoreboard_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
